// File: rtl/dmem_pkg.sv
// Shared FSM state, default sizing and response record for the data memory responder.
package dmem_pkg;
  localparam int DEPTH_WORDS_DEF = 1024;
  localparam int LATENCY_DEF     = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enable word RAM with a registered read port.
// The read register loads only on an enabled access, so it holds load data until the next access.
module dmem_array #(
  parameter int  DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Contents are intentionally never reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (en_i) rdata_q <= we_i ? '0 : mem_q[idx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed response latency.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned requests skip the array and return resp_err.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             accept, misalign;
  logic [31:0]      ram_rdata;
  resp_t            resp;
  logic             unused_addr;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = |req_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits wrap; low bits only matter for the misalign trap.
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (accept && !misalign),
    .we_i    (req_we),
    .be_i    (req_be),
    .idx_i   (req_addr[AW+1:2]),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = CNT_W'(LATENCY - 1);
        err_d   = misalign;
        state_d = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp = '0;
    if (state_q == RESP) begin
      resp.valid = 1'b1;
      resp.err   = err_q;
      resp.rdata = err_q ? '0 : ram_rdata;
    end
  end

  assign resp_valid = resp.valid;
  assign resp_err   = resp.err;
  assign resp_rdata = resp.rdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a cycle-level reference model and per-cycle compare.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding request, response due LAT edges after accept.
  logic [31:0] mdl [DEPTH];
  bit          m_busy = 0, m_rst = 0, started = 0, m_err = 0;
  longint      cyc = 0, m_due = 0;
  logic [31:0] m_data = '0;
  int unsigned m_idx;

  always @(posedge clk) begin
    started = 1;
    m_rst   = rst;
    if (rst) m_busy = 0;
    else if (m_busy) begin
      if (cyc >= m_due && resp_ready) m_busy = 0;
    end else if (req_valid) begin
      m_busy = 1;
      m_due  = cyc + LAT;
      m_err  = 0;
      m_data = '0;
      m_idx  = (req_addr / 4) % DEPTH;
      if (TRAP && req_addr[1:0] != 2'b00) m_err = 1;
      else if (req_we) begin
        for (int b = 0; b < 4; b++)
          if (req_be[b]) mdl[m_idx][8*b +: 8] = req_wdata[8*b +: 8];
      end else m_data = mdl[m_idx];
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy && !rst});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_busy && (cyc >= m_due)});
      if (m_busy && cyc >= m_due) begin
        chk("resp_rdata", resp_rdata, m_data);
        chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
      end else if (m_rst) begin
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'b0, resp_err}, 32'h0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  // Issue one request, keep junk on the request bus while busy, hold resp_ready low for 'hold' cycles.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    req_we = 1'b1; req_be = 4'hF; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) chk("resp_timeout", 32'h0, 32'h1);
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_ready_low", {31'b0, req_ready}, 32'h0);
      chk("bp_rdata_stable", resp_rdata, rd);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("idle_after_resp", {31'b0, req_ready}, 32'h1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, req_ready}, 32'h0);
    chk("reset_valid", {31'b0, resp_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);

    do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_lat", lat, 32'd2);
    chk("store_rdata", rd, 32'h0);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("load_lat", lat, 32'd2);
    chk("load_rdata", rd, 32'hDEADBEEF);
    chk("load_err", {31'b0, er}, 32'h0);

    do_req(1'b1, 4'hF, 32'h20, 32'h11223344, 0, rd, er, lat);
    do_req(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 0, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("byte_lanes", rd, 32'h11BB33DD);
    do_req(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 0, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("be_zero", rd, 32'h11BB33DD);

    do_req(1'b0, 4'h0, 32'h10, 32'h0, 5, rd, er, lat);
    chk("backpressure", rd, 32'hDEADBEEF);

    do_req(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 0, rd, er, lat);
    do_req(1'b0, 4'h0, 32'h0000, 32'h0, 0, rd, er, lat);
    chk("wrap", rd, 32'hCAFEF00D);

    do_req(1'b0, 4'h0, 32'h12, 32'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_err", {31'b0, er}, 32'h1);
    chk("misalign_rdata", rd, 32'h0);
`else
    chk("misalign_err", {31'b0, er}, 32'h0);
    chk("misalign_rdata", rd, 32'hDEADBEEF);
`endif

    // Reset one cycle after accepting a load
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 32'h20;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_mid_rst", {31'b0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_resp_after_rst", {31'b0, resp_valid}, 32'h0);
    end
    do_req(1'b0, 4'h0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("kept_after_rst", rd, 32'h11BB33DD);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("kept_after_rst2", rd, 32'hDEADBEEF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to response valid, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_be, input, 4: byte-lane write enables; ignored for loads.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data.
REQ-011 SHALL have port resp_valid, output, 1: response present.
REQ-012 SHALL have port resp_ready, input, 1: initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32: load data; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1: access error flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
REQ-017 SHALL, on accept: IDLE->WAIT if LATENCY>1, else IDLE->RESP; load the latency counter with LATENCY-1.
REQ-018 SHALL decrement the counter in WAIT and go to RESP when it reaches 0, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then go to IDLE; there is no back-to-back accept in the same cycle.
REQ-020 SHALL form the word index from req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-021 SHALL commit a store on the accept edge, writing only the lanes set in req_be; req_be=0 writes nothing but still returns a response.
REQ-022 SHALL capture load data from the array on the accept edge and register it until the response is consumed.
REQ-023 SHALL ignore request inputs outside IDLE.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, force IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0 for that cycle; req_ready returns to 1 the cycle after rst falls.
REQ-025 SHALL, on reset mid-operation, drop any pending response; a store already committed is kept; array contents are never cleared by reset.

Configuration
REQ-026 SHALL support macro DMEM_MISALIGN_TRAP_EN.
- Defined: a request with req_addr[1:0]!=0 performs no write and no read, and returns resp_err=1 with resp_rdata=0 after the normal LATENCY.
- Undefined: req_addr[1:0] is ignored and resp_err is tied to 0.

Structure
REQ-027 SHALL place the FSM state enum, default DEPTH_WORDS/LATENCY constants and the response record typedef in shared package dmem_pkg.
REQ-028 SHALL instantiate one sub-module, dmem_array: a synchronous single-port byte-enable RAM with registered read.

Verification
REQ-029 Store then load: store 0xDEADBEEF to addr 0x10 with be=0xF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after each accept.
REQ-030 Byte lanes: on word 0x11223344, store 0xAABBCCDD with be=0x5, then load -> 0x11BB33DD.
REQ-031 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-032 Wrap: with DEPTH_WORDS=1024, store to 0x1000 then load 0x0000 -> same data.
REQ-033 Reset mid-WAIT: assert rst one cycle after accepting a load -> resp_valid never asserts; req_ready=1 the cycle after rst=0; earlier stores still readable.
REQ-034 Misalign: load 0x12 -> with DMEM_MISALIGN_TRAP_EN, resp_err=1 and resp_rdata=0; without it, resp_err=0 and data from word 0x10.
